// File: rtl/mem_mpu_multi_pkg.sv
// Shared definitions for the multi-region MPU: FSM states, config window layout
// and bit positions inside config words.
package mem_mpu_multi_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_CHECK, ST_RDWAIT, ST_RESP} state_t;

    // Per-region word offsets inside a 4-word group
    localparam logic [1:0] OFF_BASE  = 2'd0;
    localparam logic [1:0] OFF_LIMIT = 2'd1;
    localparam logic [1:0] OFF_PCLO  = 2'd2;
    localparam logic [1:0] OFF_PCHI  = 2'd3;

    // Offsets inside the trailing control group
    localparam logic [1:0] OFF_CTRL  = 2'd0;
    localparam logic [1:0] OFF_FADDR = 2'd1;
    localparam logic [1:0] OFF_FPC   = 2'd2;

    localparam int CTRL_EN    = 0;
    localparam int CTRL_LOCK  = 1;
    localparam int CTRL_FAULT = 2;

    // Bit positions inside the 3-bit {R,W,X} permission field
    localparam int PERM_X = 0;
    localparam int PERM_W = 1;
    localparam int PERM_R = 2;

    function automatic logic [2:0] need_perm(input logic inst, input logic write);
        logic [2:0] m;
        m = '0;
        if (inst)       m[PERM_X] = 1'b1;
        else if (write) m[PERM_W] = 1'b1;
        else            m[PERM_R] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/mem_mpu_multi_region_check.sv
// One protection region: address window, optional PC window and permission match.
module mem_mpu_multi_region_check #(
    parameter int ADDR_WIDTH = 22
) (
    input  logic [2:0]            perm,
    input  logic [ADDR_WIDTH-1:0] base,
    input  logic [ADDR_WIDTH-1:0] limit,
    input  logic [31:0]           pc_lo,
    input  logic [31:0]           pc_hi,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           pc,
    input  logic [2:0]            need,
    input  logic                  is_inst,
    output logic                  hit
);
    logic in_range;
    logic pc_ok;

    always_comb begin
        in_range = (base <= addr) && (addr <= limit);
        // Fetches are not bound to a code window
        pc_ok    = is_inst || ((pc_lo <= pc) && (pc <= pc_hi));
        hit      = in_range && pc_ok && |(perm & need);
    end
endmodule

// File: rtl/mem_mpu_multi.sv
// Multi-region MPU between the picorv32 native port and a 1-cycle SRAM.
// Config registers live in a word window at CFG_BASE and never reach SRAM.
module mem_mpu_multi
    import mem_mpu_multi_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 22,
    parameter int NUM_REGIONS = 4,
    parameter int CFG_BASE    = 768
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    is_inst,
    input  logic [31:0]             pc_addr,
    output logic                    inform_cpu_wait,
    input  logic                    cpu_valid,
    output logic                    cpu_ready,
    input  logic [ADDR_WIDTH-1:0]   cpu_addr,
    input  logic [DATA_WIDTH-1:0]   cpu_wdata,
    input  logic [DATA_WIDTH/8-1:0] cpu_wstrb,
    output logic [DATA_WIDTH-1:0]   cpu_rdata,
    output logic [DATA_WIDTH/8-1:0] mem_wen,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic                    fault_irq
);
    localparam logic [ADDR_WIDTH-1:0] WIN_LO   = ADDR_WIDTH'(CFG_BASE);
    localparam logic [ADDR_WIDTH-1:0] WIN_HI   = ADDR_WIDTH'(CFG_BASE + 4*NUM_REGIONS + 3);
    localparam logic [ADDR_WIDTH-3:0] GRP_CTRL = (ADDR_WIDTH-2)'(NUM_REGIONS);

    state_t state, state_nx;

    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [DATA_WIDTH-1:0]   req_wdata;
    logic [DATA_WIDTH/8-1:0] req_wstrb;
    logic                    req_inst;
    logic [31:0]             req_pc;

    logic [NUM_REGIONS-1:0][2:0]            rg_perm;
    logic [NUM_REGIONS-1:0][ADDR_WIDTH-1:0] rg_base;
    logic [NUM_REGIONS-1:0][ADDR_WIDTH-1:0] rg_limit;
    logic [NUM_REGIONS-1:0][31:0]           rg_pclo;
    logic [NUM_REGIONS-1:0][31:0]           rg_pchi;
    logic                                   cfg_en, cfg_lock, cfg_fault;
    logic [DATA_WIDTH-1:0]                  fault_addr;
    logic [31:0]                            fault_pc;

    logic [ADDR_WIDTH-1:0]  off;
    logic [ADDR_WIDTH-3:0]  grp;
    logic [1:0]             sub;
    logic                   is_win, is_write, allow;
    logic [2:0]             need;
    logic [NUM_REGIONS-1:0] hits;
    logic [DATA_WIDTH-1:0]  win_rdata;

    assign off      = req_addr - WIN_LO;
    assign grp      = off[ADDR_WIDTH-1:2];
    assign sub      = off[1:0];
    assign is_win   = (req_addr >= WIN_LO) && (req_addr <= WIN_HI);
    assign is_write = |req_wstrb;
    assign need     = need_perm(req_inst, is_write);
    assign allow    = !cfg_en || |hits;
    assign mem_addr  = req_addr;
    assign mem_wdata = req_wdata;

    for (genvar i = 0; i < NUM_REGIONS; i++) begin : g_region
        mem_mpu_multi_region_check #(.ADDR_WIDTH(ADDR_WIDTH)) u_chk (
            .perm    (rg_perm[i]),
            .base    (rg_base[i]),
            .limit   (rg_limit[i]),
            .pc_lo   (rg_pclo[i]),
            .pc_hi   (rg_pchi[i]),
            .addr    (req_addr),
            .pc      (req_pc),
            .need    (need),
            .is_inst (req_inst),
            .hit     (hits[i])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:   if (cpu_valid) state_nx = ST_CHECK;
            ST_CHECK:  state_nx = (!is_win && allow && !is_write) ? ST_RDWAIT : ST_RESP;
            ST_RDWAIT: state_nx = ST_RESP;
            default:   state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        cpu_ready       = (state == ST_RESP);
        inform_cpu_wait = (state == ST_CHECK) || (state == ST_RDWAIT);
        mem_wen         = (state == ST_CHECK && !is_win && allow) ? req_wstrb : '0;
        fault_irq       = (state == ST_CHECK) && !is_win && !allow;
    end

    always_comb begin
        win_rdata = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (grp == (ADDR_WIDTH-2)'(i)) begin
                case (sub)
                    OFF_BASE:  win_rdata = {rg_perm[i], {(DATA_WIDTH-3-ADDR_WIDTH){1'b0}}, rg_base[i]};
                    OFF_LIMIT: win_rdata = DATA_WIDTH'(rg_limit[i]);
                    OFF_PCLO:  win_rdata = DATA_WIDTH'(rg_pclo[i]);
                    default:   win_rdata = DATA_WIDTH'(rg_pchi[i]);
                endcase
            end
        end
        if (grp == GRP_CTRL) begin
            case (sub)
                OFF_CTRL:  win_rdata = DATA_WIDTH'({cfg_fault, cfg_lock, cfg_en});
                OFF_FADDR: win_rdata = fault_addr;
                OFF_FPC:   win_rdata = DATA_WIDTH'(fault_pc);
                default:   win_rdata = '0;
            endcase
        end
    end

    // Config writes land at the end of CHECK, so only later requests see them
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rg_perm    <= '0;
            rg_base    <= '0;
            rg_limit   <= '0;
            rg_pclo    <= '0;
            rg_pchi    <= '0;
            cfg_en     <= 1'b0;
            cfg_lock   <= 1'b0;
            cfg_fault  <= 1'b0;
            fault_addr <= '0;
            fault_pc   <= '0;
        end else if (state == ST_CHECK) begin
            if (is_win && is_write) begin
                if (grp == GRP_CTRL && sub == OFF_CTRL && req_wdata[CTRL_FAULT])
                    cfg_fault <= 1'b0;
                if (!cfg_lock) begin
                    for (int i = 0; i < NUM_REGIONS; i++) begin
                        if (grp == (ADDR_WIDTH-2)'(i)) begin
                            case (sub)
                                OFF_BASE: begin
                                    rg_perm[i] <= req_wdata[DATA_WIDTH-1 -: 3];
                                    rg_base[i] <= req_wdata[ADDR_WIDTH-1:0];
                                end
                                OFF_LIMIT: rg_limit[i] <= req_wdata[ADDR_WIDTH-1:0];
                                OFF_PCLO:  rg_pclo[i]  <= req_wdata[31:0];
                                default:   rg_pchi[i]  <= req_wdata[31:0];
                            endcase
                        end
                    end
                    if (grp == GRP_CTRL && sub == OFF_CTRL) begin
                        cfg_en   <= req_wdata[CTRL_EN];
                        cfg_lock <= req_wdata[CTRL_LOCK];
                    end
                end
            end else if (!is_win && !allow && !cfg_fault) begin
                cfg_fault  <= 1'b1;
                fault_addr <= {req_inst, is_write, {(DATA_WIDTH-2-ADDR_WIDTH){1'b0}}, req_addr};
                fault_pc   <= req_pc;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_addr  <= '0;
            req_wdata <= '0;
            req_wstrb <= '0;
            req_inst  <= 1'b0;
            req_pc    <= '0;
            cpu_rdata <= '0;
        end else begin
            if (state == ST_IDLE && cpu_valid) begin
                req_addr  <= cpu_addr;
                req_wdata <= cpu_wdata;
                req_wstrb <= cpu_wstrb;
                req_inst  <= is_inst;
                req_pc    <= pc_addr;
            end
            if (state == ST_CHECK)
                cpu_rdata <= (is_win && !is_write) ? win_rdata : '0;
            if (state == ST_RDWAIT)
                cpu_rdata <= mem_rdata;
        end
    end
endmodule

// File: tb/tb_mem_mpu_multi.sv
// Bench for mem_mpu_multi: behavioural MPU/SRAM model, per-cycle monitor,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mem_mpu_multi;
    localparam int DW = 32;
    localparam int AW = 22;
    localparam int NR = 4;
    localparam int CB = 768;
    localparam int CTRL = CB + 4*NR;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          is_inst = 1'b0;
    logic [31:0]   pc_addr = '0;
    logic          inform_cpu_wait;
    logic          cpu_valid = 1'b0;
    logic          cpu_ready;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic [3:0]    cpu_wstrb = '0;
    logic [DW-1:0] cpu_rdata;
    logic [3:0]    mem_wen;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          fault_irq;

    always #5 clk = ~clk;

    mem_mpu_multi #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGIONS(NR), .CFG_BASE(CB)) dut (
        .clk(clk), .reset(reset), .is_inst(is_inst), .pc_addr(pc_addr),
        .inform_cpu_wait(inform_cpu_wait), .cpu_valid(cpu_valid), .cpu_ready(cpu_ready),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb), .cpu_rdata(cpu_rdata),
        .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .fault_irq(fault_irq)
    );

    // SRAM with a bench-side preload port
    logic [31:0] sram [0:1023];
    logic        pl_en = 1'b0;
    logic [9:0]  pl_addr = '0;
    logic [31:0] pl_data = '0;
    always @(posedge clk) begin
        if (pl_en) sram[pl_addr] <= pl_data;
        else for (int b = 0; b < 4; b++)
            if (mem_wen[b]) sram[mem_addr[9:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
        mem_rdata <= sram[mem_addr[9:0]];
    end

    int checks = 0;
    int errors = 0;
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model of the programmable state and SRAM contents
    bit          m_r[NR], m_w[NR], m_x[NR];
    logic [21:0] m_base[NR], m_limit[NR];
    logic [31:0] m_pclo[NR], m_pchi[NR];
    bit          m_en, m_lock, m_fault;
    logic [31:0] m_faddr, m_fpc;
    logic [31:0] m_mem[1024];

    task automatic m_reset();
        for (int i = 0; i < NR; i++) begin
            m_r[i] = 0; m_w[i] = 0; m_x[i] = 0;
            m_base[i] = '0; m_limit[i] = '0; m_pclo[i] = '0; m_pchi[i] = '0;
        end
        m_en = 0; m_lock = 0; m_fault = 0; m_faddr = '0; m_fpc = '0;
    endtask

    function automatic bit m_allow(bit inst, logic [31:0] pc, logic [21:0] a, bit wr);
        if (!m_en) return 1'b1;
        for (int i = 0; i < NR; i++) begin
            bit p;
            p = inst ? m_x[i] : (wr ? m_w[i] : m_r[i]);
            if (p && a >= m_base[i] && a <= m_limit[i] &&
                (inst || (pc >= m_pclo[i] && pc <= m_pchi[i]))) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_cfg_read(logic [21:0] a);
        int off, g, s;
        off = int'(a) - CB; g = off / 4; s = off % 4;
        if (g < NR) begin
            case (s)
                0: return {m_r[g], m_w[g], m_x[g], 7'd0, m_base[g]};
                1: return {10'd0, m_limit[g]};
                2: return m_pclo[g];
                default: return m_pchi[g];
            endcase
        end
        case (s)
            0: return {29'd0, m_fault, m_lock, m_en};
            1: return m_faddr;
            2: return m_fpc;
            default: return 32'd0;
        endcase
    endfunction

    task automatic m_cfg_write(logic [21:0] a, logic [31:0] d);
        int off, g, s;
        off = int'(a) - CB; g = off / 4; s = off % 4;
        if (g == NR && s == 0 && d[2]) m_fault = 0;
        if (m_lock) return;
        if (g < NR) begin
            case (s)
                0: begin m_r[g] = d[31]; m_w[g] = d[30]; m_x[g] = d[29]; m_base[g] = d[21:0]; end
                1: m_limit[g] = d[21:0];
                2: m_pclo[g] = d;
                default: m_pchi[g] = d;
            endcase
        end else if (g == NR && s == 0) begin
            m_en = d[0]; m_lock = d[1];
        end
    endtask

    // Expectations handed from driver to monitor
    int          tx_id = 0, seen_id = 0, done_id = 0;
    bit          mon_en = 0, active = 0;
    int          age = 0, exp_lat = 0, got_lat = 0, irq_seen = 0;
    bit          exp_deny = 0, exp_rchk = 0;
    logic [3:0]  exp_wen = '0;
    logic [31:0] exp_rdata = '0, got_rdata = '0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (tx_id != seen_id) begin
                seen_id = tx_id; age = -1; active = 1; irq_seen = 0; got_lat = 0; got_rdata = '0;
            end
            if (active) begin
                age++;
                if (cpu_ready && got_lat == 0) begin got_lat = age; got_rdata = cpu_rdata; end
                if (fault_irq) irq_seen++;
                chk("ready", cpu_ready, age == exp_lat);
                chk("wait", inform_cpu_wait, age >= 1 && age < exp_lat);
                chk("irq", fault_irq, exp_deny && age == 1);
                chk("wen", mem_wen, (age == 1) ? exp_wen : 4'h0);
                if (age == exp_lat) begin
                    if (exp_rchk) chk("rdata", cpu_rdata, exp_rdata);
                    active = 0;
                    done_id = tx_id;
                end
            end else begin
                chk("idle_ready", cpu_ready, 0);
                chk("idle_wen", mem_wen, 0);
                chk("idle_irq", fault_irq, 0);
            end
        end
    end

    task automatic run(input bit inst, input logic [31:0] pc, input logic [21:0] a,
                       input logic [31:0] wd, input logic [3:0] ws);
        bit win, wr, ok;
        wr  = (ws != 0);
        win = (int'(a) >= CB) && (int'(a) <= CTRL + 3);
        ok  = win || m_allow(inst, pc, a, wr);
        exp_deny  = !ok;
        exp_lat   = (!win && ok && !wr) ? 3 : 2;
        exp_wen   = (!win && ok) ? ws : 4'h0;
        exp_rchk  = !wr || !ok;
        exp_rdata = !ok ? 32'd0 : (win ? m_cfg_read(a) : m_mem[a[9:0]]);
        @(posedge clk); #1;
        is_inst = inst; pc_addr = pc; cpu_addr = a; cpu_wdata = wd; cpu_wstrb = ws;
        cpu_valid = 1'b1;
        tx_id++;
        for (int w = 0; w < 20 && done_id != tx_id; w++) @(posedge clk);
        #1;
        chk("done", done_id, tx_id);
        cpu_valid = 1'b0;
        if (win && wr) m_cfg_write(a, wd);
        else if (!ok) begin
            if (!m_fault) begin m_fault = 1; m_faddr = {inst, wr, 8'd0, a}; m_fpc = pc; end
        end else if (wr) begin
            for (int b = 0; b < 4; b++) if (ws[b]) m_mem[a[9:0]][8*b +: 8] = wd[8*b +: 8];
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, cpu_ready, 0);
        chk({tag, "_rdata"}, cpu_rdata, 0);
        chk({tag, "_wen"}, mem_wen, 0);
        chk({tag, "_maddr"}, mem_addr, 0);
        chk({tag, "_mwdata"}, mem_wdata, 0);
        chk({tag, "_wait"}, inform_cpu_wait, 0);
        chk({tag, "_irq"}, fault_irq, 0);
    endtask

    initial begin
        m_reset();
        for (int i = 0; i < 1024; i++) begin
            @(negedge clk);
            pl_en = 1'b1; pl_addr = 10'(i);
            pl_data = (i == 5) ? 32'hA5A5_A5A5 : $urandom;
            m_mem[i] = pl_data;
        end
        @(negedge clk); pl_en = 1'b0;
        chk_reset_outputs("rst");
        @(posedge clk); #1; reset = 1'b0; mon_en = 1'b1;

        // Pass-through read
        run(0, 32'h40, 22'd5, 32'd0, 4'h0);
        chk("t1_rdata", got_rdata, 32'hA5A5_A5A5);
        chk("t1_lat", got_lat, 3);

        // Region0 RWX over words 0..255, code 0..0x3FF
        run(0, 0, 22'(CB + 0), 32'hE000_0000, 4'hF);
        run(0, 0, 22'(CB + 1), 32'd255, 4'hF);
        run(0, 0, 22'(CB + 2), 32'd0, 4'hF);
        run(0, 0, 22'(CB + 3), 32'h3FF, 4'hF);
        run(0, 0, 22'(CTRL), 32'h1, 4'hF);
        run(0, 32'h40, 22'd10, 32'h1234_5678, 4'hF);
        chk("t2_sram", sram[10], 32'h1234_5678);
        chk("t2_irq", irq_seen, 0);
        chk("t2_lat", got_lat, 2);

        run(0, 32'h40, 22'd300, 32'hDEAD_BEEF, 4'hF);
        chk("t3_irq", irq_seen, 1);
        chk("t3_rdata", got_rdata, 0);
        chk("t3_nowrite", sram[300], m_mem[300]);
        run(0, 0, 22'(CTRL + 1), 32'd0, 4'h0);
        chk("t3_faddr", got_rdata, 32'h4000_012C);

        // Read-only region, data access from outside the code window
        run(0, 0, 22'(CTRL), 32'h5, 4'hF);
        run(0, 0, 22'(CB + 0), 32'h8000_0000, 4'hF);
        run(0, 32'h800, 22'd10, 32'd0, 4'h0);
        chk("t4_irq", irq_seen, 1);
        run(0, 32'h900, 22'd10, 32'd0, 4'h0);
        run(0, 0, 22'(CTRL + 2), 32'd0, 4'h0);
        chk("t4_fpc_kept", got_rdata, 32'h800);
        run(0, 0, 22'(CTRL), 32'h5, 4'hF);
        run(0, 0, 22'(CTRL), 32'd0, 4'h0);
        chk("t4_w1c", got_rdata, 32'h1);

        // Lock freezes config, fault clear still works
        run(0, 0, 22'(CTRL), 32'h3, 4'hF);
        run(0, 0, 22'(CB + 1), 32'd1023, 4'hF);
        run(0, 0, 22'(CB + 1), 32'd0, 4'h0);
        chk("t5_limit", got_rdata, 32'd255);
        run(0, 32'h800, 22'd10, 32'd0, 4'h0);
        run(0, 0, 22'(CTRL), 32'd0, 4'h0);
        chk("t5_ctrl_fault", got_rdata, 32'h7);
        run(0, 0, 22'(CTRL), 32'h4, 4'hF);
        run(0, 0, 22'(CTRL), 32'd0, 4'h0);
        chk("t5_ctrl_clr", got_rdata, 32'h3);

        // Reset while the SRAM read is outstanding
        mon_en = 1'b0;
        @(posedge clk); #1;
        is_inst = 0; pc_addr = 32'h40; cpu_addr = 22'd10; cpu_wstrb = 4'h0; cpu_wdata = '0;
        cpu_valid = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        chk("t6_rdwait", inform_cpu_wait, 1);
        reset = 1'b1; #1;
        chk_reset_outputs("t6");
        cpu_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t6_noready", cpu_ready, 0);
        end
        @(posedge clk); #1; reset = 1'b0;
        m_reset();
        mon_en = 1'b1;
        run(0, 0, 22'd5, 32'd0, 4'h0);
        chk("t6_post", got_rdata, 32'hA5A5_A5A5);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            int kind;
            kind = $urandom_range(0, 9);
            if (kind < 3) begin
                int off;
                logic [31:0] d;
                off = $urandom_range(0, 4*NR + 3);
                case (off % 4)
                    0: d = (off / 4 == NR) ?
                           {29'd0, 1'($urandom_range(0, 1)), ($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0)} :
                           {3'($urandom), 7'd0, 22'($urandom_range(0, 1023))};
                    1: d = $urandom_range(0, 1023);
                    2: d = $urandom_range(0, 32'h800);
                    default: d = $urandom_range(0, 32'hFFF);
                endcase
                if ($urandom_range(0, 1)) run(0, 0, 22'(CB + off), d, 4'hF);
                else run(0, 0, 22'(CB + off), 32'd0, 4'h0);
            end else begin
                bit inst;
                logic [3:0] ws;
                inst = ($urandom_range(0, 3) == 0);
                ws = (inst || $urandom_range(0, 1)) ? 4'h0 : 4'($urandom);
                run(inst, $urandom_range(0, 32'hFFF), 22'($urandom_range(0, 1023)), $urandom, ws);
            end
        end

        begin
            int mism;
            mism = 0;
            for (int i = 0; i < 1024; i++) if (sram[i] !== m_mem[i]) mism++;
            chk("sram_final", mism, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
